alu_muldiv_unit: RTL and testbench
==================================

// Module: alu_muldiv_unit
// PURPOSE
//  Parametrised iterative multiply/divide unit with HI/LO registers, sitting beside the execute-stage ALU.
//  Executes MULT/MULTU/DIV/DIVU over several cycles behind a start/busy/done handshake.
//  Also executes MTHI/MTLO; hi/lo are always readable for MFHI/MFLO.
//  Decode holds the pipeline while busy=1.
// PARAMETERS
//  WIDTH      32  operand width; hi/lo are each WIDTH bits; even, >=8
//  CNT_W      $clog2(WIDTH+1)  iteration counter width (derived, do not override)
// PORTS
//  clock        in   1      rising-edge clock
//  reset        in   1      synchronous, active-high
//  start        in   1      issue op; accepted only when busy=0
//  op           in   3      0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO; 6,7 reserved (ignored)
//  a            in   WIDTH  rs operand (multiplicand / dividend / MTxx source)
//  b            in   WIDTH  rt operand (multiplier / divisor)
//  busy         out  1      high from accept until the cycle done is high
//  done         out  1      one-cycle pulse; hi/lo hold new values in that cycle
//  div_by_zero  out  1      pulses with done when DIV/DIVU had b==0
//  hi           out  WIDTH  HI register
//  lo           out  WIDTH  LO register
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0.
//  FSM: IDLE -> RUN (mul/div accept) -> FIX -> IDLE; IDLE -> WB (MTHI/MTLO accept) -> IDLE.
//  Accept: start=1 && busy=0 at edge E; operands and op latched at E; busy=1 after E.
//   start while busy=1: ignored, no state change. Reserved op: ignored, stays IDLE.
//  Signed ops: latch |a|, |b|; record result signs. Unsigned ops: operands used as is.
//  RUN: exactly WIDTH cycles, one bit per cycle; counter counts WIDTH-1 down to 0.
//   MUL: shift-add into a 2*WIDTH accumulator. DIV: restoring, one quotient bit per cycle.
//  FIX (1 cycle): apply sign correction, write hi/lo, done=1, busy=0 after that edge.
//   MUL: {hi,lo} = 2*WIDTH product, two's-complement negated if signs differ.
//   DIV: lo = quotient, truncated toward zero; hi = remainder with sign of dividend.
//  Latency: start accepted at edge E -> done high after edge E+WIDTH+1.
//   busy is high for WIDTH+1 cycles.
//  Divide by zero: no iteration effect. At FIX: hi=a (as latched), lo=all-ones, div_by_zero=1.
//   Same latency as a normal divide.
//  Signed overflow (a = -2^(WIDTH-1), b = -1): lo = -2^(WIDTH-1), hi = 0; no flag.
//  WB: MTHI writes hi=a, MTLO writes lo=a at the edge after accept.
//   done=1 in the WB cycle; the other register is unchanged.
//  hi/lo change only in the FIX/WB cycle; mid-operation they hold the previous result.
//  start on the same edge as done: accepted only when busy=0, so not accepted in the FIX cycle.
//  Reset mid-operation: aborts. All outputs return to reset values at that edge; no done pulse.
// CONFIGURATION
//  ALU_FAST_MUL_EN defined: MULT/MULTU skip RUN (IDLE -> FIX).
//   Single-cycle combinational WIDTH x WIDTH multiply registered in FIX.
//   Latency 1 edge after accept; divide is unchanged.
//  Not defined: all multiplies are iterative, WIDTH+1 latency as above.
// STRUCTURE
//  Shared package alu_pkg:
//   op encodings (OP_MULT..OP_MTLO) as localparams.
//   FSM state encoding (S_IDLE, S_RUN, S_FIX, S_WB).
//  Sub-module muldiv_div_core:
//   restoring divide datapath (remainder/quotient shift registers, one step per enable).
//   The top keeps the FSM, counter, sign logic, multiplier accumulator and hi/lo.
// TESTING (WIDTH=32)
//  1. MULTU a=6 b=7 at edge 0 -> done after edge 33; hi=0, lo=42; busy high for 33 cycles.
//  2. MULT a=0xFFFFFFFF(-1) b=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF.
//     MULTU same operands -> hi=0, lo=0xFFFFFFFF.
//  3. DIV a=-7 b=2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
//     DIVU a=7 b=2 -> lo=3, hi=1.
//  4. DIVU a=7 b=0 -> after 33 edges: done=1, div_by_zero=1, hi=7, lo=0xFFFFFFFF.
//  5. Start DIV, re-pulse start with MTLO a=5 at edge 10 -> ignored.
//     Result as item 3; then MTLO a=5 -> lo=5, hi unchanged, done after 1 edge.
//  6. MULT in flight, reset=1 at edge 12 -> busy=0, hi=lo=0, no done.
//     With ALU_FAST_MUL_EN: MULTU 6*7 -> done after edge 1, lo=42.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes and FSM states.
package alu_pkg;

  // Operation codes presented on the op port
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // Control FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_WB   = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring divider datapath: unsigned magnitudes, one quotient bit per enabled cycle.
// After WIDTH enabled steps quotient/remainder hold the unsigned result.
module muldiv_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;

  // Trial subtraction of the divisor from the partial remainder with the next dividend bit
  always_comb begin
    shifted = {rem_reg, quo_reg[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_reg};
    fits    = ~diff[WIDTH];
  end

  // Remainder/quotient shift registers; the dividend shifts out of quo_reg as quotient bits shift in
  always_ff @(posedge clock) begin
    if (reset) begin
      rem_reg <= '0;
      quo_reg <= '0;
      dvs_reg <= '0;
    end else if (load) begin
      rem_reg <= '0;
      quo_reg <= dividend;
      dvs_reg <= divisor;
    end else if (enable) begin
      rem_reg <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo_reg <= {quo_reg[WIDTH-2:0], fits};
    end
  end

  assign quotient  = quo_reg;
  assign remainder = rem_reg;

endmodule

// File: rtl/alu_muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers and a start/busy/done handshake.
// Build option ALU_FAST_MUL_EN: multiplies bypass the iterative loop and use a
// single combinational multiplier registered in the fix-up cycle.
module alu_muldiv_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2:0]         op_reg;
  logic               neg_a_reg, neg_b_reg, dbz_reg;
  logic [WIDTH-1:0]   mcand_reg, hi_reg, lo_reg;
  logic [2*WIDTH-1:0] prod_reg, prod_step, prod_mag, prod_fix;
  logic               done_reg, dbz_out_reg;

  logic               accept, op_signed_in, neg_a_in, neg_b_in;
  logic [WIDTH-1:0]   abs_a_in, abs_b_in;
  logic               is_mul_op, div_en;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   quo, rem, quo_fix, rem_fix, a_orig;

  // Operand conditioning at issue: signed ops are reduced to magnitudes plus sign flags
  always_comb begin
    accept       = start && (state_reg == S_IDLE);
    op_signed_in = (op == OP_MULT) || (op == OP_DIV);
    neg_a_in     = op_signed_in && a[WIDTH-1];
    neg_b_in     = op_signed_in && b[WIDTH-1];
    abs_a_in     = neg_a_in ? -a : a;
    abs_b_in     = neg_b_in ? -b : b;
    is_mul_op    = (op_reg == OP_MULT) || (op_reg == OP_MULTU);
    div_en       = (state_reg == S_RUN) && !is_mul_op && !dbz_reg;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; reserved op codes leave the unit idle
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          case (op)
`ifdef ALU_FAST_MUL_EN
            OP_MULT, OP_MULTU: state_next = S_FIX;
`else
            OP_MULT, OP_MULTU: state_next = S_RUN;
`endif
            OP_DIV, OP_DIVU:   state_next = S_RUN;
            OP_MTHI, OP_MTLO:  state_next = S_WB;
            default:           state_next = S_IDLE;
          endcase
        end
      end
      S_RUN:   if (cnt_reg == '0) state_next = S_FIX;
      S_FIX:   state_next = S_IDLE;
      S_WB:    state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs: busy covers every non-idle cycle, the rest are registered pulses
  always_comb begin
    busy        = (state_reg != S_IDLE);
    done        = done_reg;
    div_by_zero = dbz_out_reg;
    hi          = hi_reg;
    lo          = lo_reg;
  end

  // One shift-add step: add multiplicand when the current multiplier bit is set, then shift right
  always_comb begin
    mul_sum   = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + (prod_reg[0] ? {1'b0, mcand_reg} : '0);
    prod_step = {mul_sum, prod_reg[WIDTH-1:1]};
  end

  // Sign correction applied in the fix-up cycle
  always_comb begin
`ifdef ALU_FAST_MUL_EN
    prod_mag = {{WIDTH{1'b0}}, mcand_reg} * {{WIDTH{1'b0}}, prod_reg[WIDTH-1:0]};
`else
    prod_mag = prod_reg;
`endif
    prod_fix = (neg_a_reg ^ neg_b_reg) ? -prod_mag : prod_mag;
    quo_fix  = (neg_a_reg ^ neg_b_reg) ? -quo : quo;
    rem_fix  = neg_a_reg ? -rem : rem;
    // Reconstructs the dividend as issued (negating the magnitude is exact even for the most negative value)
    a_orig   = neg_a_reg ? -mcand_reg : mcand_reg;
  end

  // Datapath: operand latches, iteration counter, multiplier accumulator and HI/LO writeback
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg     <= '0;
      op_reg      <= '0;
      neg_a_reg   <= 1'b0;
      neg_b_reg   <= 1'b0;
      dbz_reg     <= 1'b0;
      mcand_reg   <= '0;
      prod_reg    <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      done_reg    <= 1'b0;
      dbz_out_reg <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      dbz_out_reg <= 1'b0;
      if (accept) begin
        op_reg    <= op;
        neg_a_reg <= neg_a_in;
        neg_b_reg <= neg_b_in;
        mcand_reg <= abs_a_in;
        prod_reg  <= {{WIDTH{1'b0}}, abs_b_in};
        dbz_reg   <= (b == '0);
        if (state_next == S_RUN) cnt_reg <= CNT_W'(WIDTH - 1);
      end
      if (state_reg == S_RUN) begin
        if (cnt_reg != '0) cnt_reg <= cnt_reg - CNT_W'(1);
        if (is_mul_op) prod_reg <= prod_step;
      end
      if (state_reg == S_FIX) begin
        done_reg <= 1'b1;
        if (is_mul_op) begin
          {hi_reg, lo_reg} <= prod_fix;
        end else if (dbz_reg) begin
          hi_reg      <= a_orig;
          lo_reg      <= '1;
          dbz_out_reg <= 1'b1;
        end else begin
          hi_reg <= rem_fix;
          lo_reg <= quo_fix;
        end
      end
      if (state_reg == S_WB) begin
        done_reg <= 1'b1;
        if (op_reg == OP_MTHI) hi_reg <= mcand_reg;
        else                   lo_reg <= mcand_reg;
      end
    end
  end

  muldiv_div_core #(.WIDTH(WIDTH)) u_div_core (
    .clock     (clock),
    .reset     (reset),
    .load      (accept),
    .enable    (div_en),
    .dividend  (abs_a_in),
    .divisor   (abs_b_in),
    .quotient  (quo),
    .remainder (rem)
  );

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Self-checking bench for alu_muldiv_unit (WIDTH=32): directed cases plus random ops
// checked against an arithmetic reference model of HI/LO.
module tb_alu_muldiv_unit;

  localparam logic [2:0] T_MULT = 3'd0, T_MULTU = 3'd1, T_DIV = 3'd2, T_DIVU = 3'd3,
                         T_MTHI = 3'd4, T_MTLO = 3'd5;
`ifdef ALU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi, m_lo;
  logic        m_dbz;

  alu_muldiv_unit #(.WIDTH(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: results from plain integer arithmetic on the architectural operands
  task automatic model(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       output int lat);
    logic [63:0] p;
    int sa, sb;
    m_dbz = 1'b0;
    lat = 1;
    case (o)
      T_MULT: begin
        p = longint'($signed(aa)) * longint'($signed(bb));
        {m_hi, m_lo} = p;
        lat = MUL_LAT;
      end
      T_MULTU: begin
        p = {32'd0, aa} * {32'd0, bb};
        {m_hi, m_lo} = p;
        lat = MUL_LAT;
      end
      T_DIV, T_DIVU: begin
        lat = DIV_LAT;
        if (bb == 32'd0) begin
          m_hi = aa; m_lo = 32'hFFFF_FFFF; m_dbz = 1'b1;
        end else if (o == T_DIV && aa == 32'h8000_0000 && bb == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000; m_hi = 32'd0;
        end else if (o == T_DIV) begin
          sa = $signed(aa); sb = $signed(bb);
          m_lo = sa / sb; m_hi = sa % sb;
        end else begin
          m_lo = aa / bb; m_hi = aa % bb;
        end
      end
      T_MTHI: m_hi = aa;
      T_MTLO: m_lo = aa;
      default: ;
    endcase
  endtask

  // Issue one op, follow it to done, and check latency, busy span, hold behaviour and results.
  // glitch > 0 drives a stray MTLO start so that it is sampled at that edge after accept.
  task automatic do_op(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       input int glitch);
    logic [31:0] prev_hi, prev_lo;
    int lat, n, busy_cycles;
    prev_hi = m_hi;
    prev_lo = m_lo;
    model(o, aa, bb, lat);
    @(negedge clock);
    start = 1'b1; op = o; a = aa; b = bb;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && n < 200) begin
      if (busy === 1'b1) busy_cycles++;
      if (n == 3 && lat > 4) begin
        check("hold_hi", hi, prev_hi);
        check("hold_lo", lo, prev_lo);
      end
      if (n + 1 == glitch) begin
        start = 1'b1; op = T_MTLO; a = 32'd5;
      end
      @(posedge clock); #1;
      start = 1'b0; op = o; a = aa;
      n++;
    end
    check("latency", n, lat);
    check("busy_span", busy_cycles, lat);
    check("busy_at_done", busy, 1'b0);
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    check("div_by_zero", div_by_zero, m_dbz);
    @(posedge clock); #1;
    check("done_pulse", done, 1'b0);
    check("dbz_pulse", div_by_zero, 1'b0);
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d latency=%0d", o, aa, bb, hi, lo,
             div_by_zero, n);
  endtask

  initial begin
    int dcount;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dbz", div_by_zero, 1'b0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    do_op(T_MULTU, 32'd6, 32'd7, -1);
    do_op(T_MULT,  32'hFFFF_FFFF, 32'd1, -1);
    do_op(T_MULTU, 32'hFFFF_FFFF, 32'd1, -1);
    do_op(T_DIV,   32'hFFFF_FFF9, 32'd2, -1);
    do_op(T_DIVU,  32'd7, 32'd2, -1);
    do_op(T_DIVU,  32'd7, 32'd0, -1);
    do_op(T_DIV,   32'hFFFF_FFF9, 32'd2, 10);
    do_op(T_MTLO,  32'd5, 32'd0, -1);
    do_op(T_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1);
    do_op(T_DIV,   32'hFFFF_FFF9, 32'd0, -1);
    do_op(T_MTHI,  32'h1234_5678, 32'd0, -1);
    do_op(T_MULT,  32'h8000_0000, 32'h8000_0000, -1);

    // Reserved op code: ignored, nothing changes
    @(negedge clock);
    start = 1'b1; op = 3'd6; a = 32'hDEAD_BEEF; b = 32'd3;
    @(posedge clock); #1;
    start = 1'b0;
    check("rsv_busy", busy, 1'b0);
    @(posedge clock); #1;
    check("rsv_done", done, 1'b0);
    check("rsv_hi", hi, m_hi);
    check("rsv_lo", lo, m_lo);
    $display("op=6 (reserved) -> busy=%0d done=%0d", busy, done);

    // Reset in the middle of an iterative operation
    @(negedge clock);
    start = 1'b1;
`ifdef ALU_FAST_MUL_EN
    op = T_DIV;
`else
    op = T_MULT;
`endif
    a = 32'd12345; b = 32'd77;
    @(posedge clock); #1;
    start = 1'b0;
    dcount = 0;
    for (int i = 0; i < 11; i++) begin
      @(posedge clock); #1;
      if (done === 1'b1) dcount++;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_done", done, 1'b0);
    m_hi = '0; m_lo = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (done === 1'b1) dcount++;
    end
    check("abort_no_done", dcount, 0);
    $display("reset mid-op -> busy=%0d hi=%h lo=%h done_count=%0d", busy, hi, lo, dcount);

    // Random operations against the reference model
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 5));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: ra = 32'h8000_0000;
        default: ;
      endcase
      do_op(ro, ra, rb, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
